// File: rtl/lsq_fwd_profiler_pkg.sv
// Shared definitions for the store-to-load forwarding profiler.
// Contents:
//   - Default entry counts and the counter width.
//   - lsq_fwd_cnt_e: counter index enum, 3 bits.
//   - Store and load byte-mask helpers, shared with the forwarding logic.
package lsq_fwd_profiler_pkg;

  localparam int unsigned DefStEntries = 8;
  localparam int unsigned DefLdEntries = 8;
  localparam int unsigned DefCntW      = 32;
  // Indices 0..5 are backed by real counters; 6 and 7 read as zero.
  localparam int unsigned NumCnt       = 6;

  typedef enum logic [2:0] {
    CntCycles       = 3'd0,
    CntBothNonempty = 3'd1,
    CntCycFull      = 3'd2,
    CntFullLoads    = 3'd3,
    CntPartLoads    = 3'd4,
    CntMaxFull      = 3'd5,
    CntRsvd6        = 3'd6,
    CntRsvd7        = 3'd7
  } lsq_fwd_cnt_e;

  // Bytes written by a store. Unknown funct3 yields an empty mask, so it never matches.
  function automatic logic [3:0] st_byte_mask(input logic [2:0] funct3, input logic [1:0] a);
    logic [3:0] m;
    case (funct3)
      3'b000:  m = 4'b0001 << a;
      3'b001:  m = 4'b0011 << a;
      3'b010:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Bytes read by a load. Signed and unsigned variants share a mask; the rest read a word.
  function automatic logic [3:0] ld_byte_mask(input logic [2:0] funct3, input logic [1:0] a);
    logic [3:0] m;
    case (funct3)
      3'b000, 3'b100: m = 4'b0001 << a;
      3'b001, 3'b101: m = 4'b0011 << a;
      default:        m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsq_fwd_profiler_if.sv
// Observation and counter-read bundle for lsq_fwd_profiler.
// Signals:
//   - en, clr: sample enable and synchronous clear.
//   - st_*: store-queue entries. ld_*: load-RS entries.
//   - rd_req/rd_sel: counter read request. rd_valid/rd_data: one-cycle response.
// Modports: master drives the observation and request side; slave is the profiler.
interface lsq_fwd_profiler_if #(
  parameter int unsigned ST_ENTRIES = 8,
  parameter int unsigned LD_ENTRIES = 8,
  parameter int unsigned CNT_W      = 32
) ();

  logic                        en;
  logic                        clr;
  logic [ST_ENTRIES-1:0]       st_valid;
  logic [ST_ENTRIES-1:0]       st_addr_valid;
  logic [ST_ENTRIES-1:0][31:0] st_addr;
  logic [ST_ENTRIES-1:0][2:0]  st_funct3;
  logic [LD_ENTRIES-1:0]       ld_valid;
  logic [LD_ENTRIES-1:0]       ld_addr_valid;
  logic [LD_ENTRIES-1:0][31:0] ld_addr;
  logic [LD_ENTRIES-1:0][2:0]  ld_funct3;
  logic                        rd_req;
  logic [2:0]                  rd_sel;
  logic                        rd_valid;
  logic [CNT_W-1:0]            rd_data;

  modport master (
    output en, clr, st_valid, st_addr_valid, st_addr, st_funct3,
    output ld_valid, ld_addr_valid, ld_addr, ld_funct3, rd_req, rd_sel,
    input  rd_valid, rd_data
  );

  modport slave (
    input  en, clr, st_valid, st_addr_valid, st_addr, st_funct3,
    input  ld_valid, ld_addr_valid, ld_addr, ld_funct3, rd_req, rd_sel,
    output rd_valid, rd_data
  );

endinterface

// File: rtl/lsq_fwd_pair.sv
// Classifies one store/load pair as a full or partial forwarding opportunity.
// Ports:
//   - st_*: one store entry (valid, address resolved, byte address, funct3).
//   - ld_*: one load entry, same fields.
//   - full: the store covers every byte the load reads.
//   - partial: the byte sets overlap but the store does not cover the whole load.
module lsq_fwd_pair
  import lsq_fwd_profiler_pkg::*;
(
  input  logic        st_valid,
  input  logic        st_addr_valid,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_funct3,
  input  logic        ld_valid,
  input  logic        ld_addr_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_funct3,
  output logic        full,
  output logic        partial
);

  logic       same_word;
  logic [3:0] st_mask;
  logic [3:0] ld_mask;
  logic [3:0] overlap;

  always_comb begin
    same_word = st_valid && st_addr_valid && ld_valid && ld_addr_valid &&
                (st_addr[31:2] == ld_addr[31:2]);
    st_mask   = st_byte_mask(st_funct3, st_addr[1:0]);
    ld_mask   = ld_byte_mask(ld_funct3, ld_addr[1:0]);
    overlap   = st_mask & ld_mask;
    // Load masks are never empty, so an empty store mask cannot satisfy the full test.
    full      = same_word && (overlap == ld_mask);
    partial   = same_word && (overlap != 4'b0000) && (overlap != ld_mask);
  end

endmodule

// File: rtl/lsq_fwd_profiler.sv
// Store-to-load forwarding performance monitor.
// Ports:
//   - clk, rst: clock; synchronous active-high reset.
//   - bus (slave): observation of store/load entries, en/clr, and the counter read port.
// Pipeline:
//   - Stage 0: pair grid plus per-load classification, combinational.
//   - Stage 1: registered popcounts.
//   - Stage 2: saturating counters.
// A read returns the registered counter value one cycle after rd_req.
module lsq_fwd_profiler
  import lsq_fwd_profiler_pkg::*;
#(
  parameter int unsigned ST_ENTRIES = DefStEntries,
  parameter int unsigned LD_ENTRIES = DefLdEntries,
  parameter int unsigned CNT_W      = DefCntW
) (
  input logic                clk,
  input logic                rst,
  lsq_fwd_profiler_if.slave  bus
);

  localparam int unsigned NfW  = $clog2(LD_ENTRIES + 1);
  localparam int unsigned AddW = ((CNT_W > NfW) ? CNT_W : NfW) + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Stage 0: pair grid, indexed [load][store].
  logic [LD_ENTRIES-1:0][ST_ENTRIES-1:0] pair_full;
  logic [LD_ENTRIES-1:0][ST_ENTRIES-1:0] pair_part;
  logic [LD_ENTRIES-1:0]                 ld_full;
  logic [LD_ENTRIES-1:0]                 ld_part;

  for (genvar gj = 0; gj < LD_ENTRIES; gj++) begin : g_ld
    for (genvar gi = 0; gi < ST_ENTRIES; gi++) begin : g_st
      lsq_fwd_pair u_pair (
        .st_valid      (bus.st_valid[gi]),
        .st_addr_valid (bus.st_addr_valid[gi]),
        .st_addr       (bus.st_addr[gi]),
        .st_funct3     (bus.st_funct3[gi]),
        .ld_valid      (bus.ld_valid[gj]),
        .ld_addr_valid (bus.ld_addr_valid[gj]),
        .ld_addr       (bus.ld_addr[gj]),
        .ld_funct3     (bus.ld_funct3[gj]),
        .full          (pair_full[gj][gi]),
        .partial       (pair_part[gj][gi])
      );
    end
    // A full match anywhere wins, so each load lands in at most one class.
    assign ld_full[gj] = |pair_full[gj];
    assign ld_part[gj] = !ld_full[gj] && (|pair_part[gj]);
  end

  function automatic logic [NfW-1:0] popcnt(input logic [LD_ENTRIES-1:0] v);
    logic [NfW-1:0] c;
    c = '0;
    for (int k = 0; k < LD_ENTRIES; k++) begin
      c = c + NfW'(v[k]);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [NfW-1:0]   b);
    logic [AddW-1:0] s;
    s = AddW'(a) + AddW'(b);
    return (s > AddW'(CntMax)) ? CntMax : s[CNT_W-1:0];
  endfunction

  logic [NfW-1:0] nfull_s0;
  logic [NfW-1:0] npart_s0;
  logic           both_s0;

  always_comb begin
    nfull_s0 = popcnt(ld_full);
    npart_s0 = popcnt(ld_part);
    both_s0  = (|bus.st_valid) && (|bus.ld_valid);
  end

  // Stage 1.
  logic           s1_vld_q;
  logic [NfW-1:0] s1_nfull_q;
  logic [NfW-1:0] s1_npart_q;
  logic           s1_both_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_nfull_q <= '0;
      s1_npart_q <= '0;
      s1_both_q  <= 1'b0;
    end else begin
      s1_vld_q   <= bus.en && !bus.clr;
      s1_nfull_q <= nfull_s0;
      s1_npart_q <= npart_s0;
      s1_both_q  <= both_s0;
    end
  end

  // Stage 2: counters.
  logic [CNT_W-1:0] cnt_q [NumCnt];
  logic [CNT_W-1:0] cnt_d [NumCnt];
  logic [CNT_W-1:0] nfull_ext;

  always_comb begin
    nfull_ext = sat_add('0, s1_nfull_q);
    for (int k = 0; k < NumCnt; k++) begin
      cnt_d[k] = cnt_q[k];
    end
    if (bus.clr) begin
      for (int k = 0; k < NumCnt; k++) begin
        cnt_d[k] = '0;
      end
    end else if (s1_vld_q) begin
      cnt_d[CntCycles]       = sat_add(cnt_q[CntCycles], NfW'(1));
      cnt_d[CntBothNonempty] = sat_add(cnt_q[CntBothNonempty], NfW'(s1_both_q));
      cnt_d[CntCycFull]      = sat_add(cnt_q[CntCycFull], NfW'(s1_nfull_q != '0));
      cnt_d[CntFullLoads]    = sat_add(cnt_q[CntFullLoads], s1_nfull_q);
      cnt_d[CntPartLoads]    = sat_add(cnt_q[CntPartLoads], s1_npart_q);
      if (nfull_ext > cnt_q[CntMaxFull]) begin
        cnt_d[CntMaxFull] = nfull_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NumCnt; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumCnt; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Read port samples the registered counters, so a same-cycle clr returns the old value.
  logic [CNT_W-1:0] rd_data_d;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = '0;
    unique case (lsq_fwd_cnt_e'(bus.rd_sel))
      CntCycles:       rd_data_d = cnt_q[CntCycles];
      CntBothNonempty: rd_data_d = cnt_q[CntBothNonempty];
      CntCycFull:      rd_data_d = cnt_q[CntCycFull];
      CntFullLoads:    rd_data_d = cnt_q[CntFullLoads];
      CntPartLoads:    rd_data_d = cnt_q[CntPartLoads];
      CntMaxFull:      rd_data_d = cnt_q[CntMaxFull];
      CntRsvd6:        rd_data_d = '0;
      CntRsvd7:        rd_data_d = '0;
      default:         rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_lsq_fwd_profiler.sv
// Self-checking bench for lsq_fwd_profiler: a 32-bit-counter instance for function and
// timing, and a 4-bit-counter instance for saturation. Read responses are checked
// against a queue of expected values filled when each request is driven.
module tb_lsq_fwd_profiler;
  import lsq_fwd_profiler_pkg::*;

  localparam int ST = 8;
  localparam int LD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsq_fwd_profiler_if #(.ST_ENTRIES(ST), .LD_ENTRIES(LD), .CNT_W(32)) m_if ();
  lsq_fwd_profiler_if #(.ST_ENTRIES(ST), .LD_ENTRIES(LD), .CNT_W(4))  s_if ();

  lsq_fwd_profiler #(.ST_ENTRIES(ST), .LD_ENTRIES(LD), .CNT_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  lsq_fwd_profiler #(.ST_ENTRIES(ST), .LD_ENTRIES(LD), .CNT_W(4)) u_dut_small (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          sel;
    logic [31:0] val;
  } rd_exp_t;

  rd_exp_t m_q[$];
  rd_exp_t s_q[$];
  logic    m_req_prev;
  logic    s_req_prev;

  always @(posedge clk) begin
    m_req_prev <= rst ? 1'b0 : m_if.rd_req;
    s_req_prev <= rst ? 1'b0 : s_if.rd_req;
  end

  always @(negedge clk) begin
    rd_exp_t e;
    if (!rst) begin
      if (m_if.rd_valid || m_req_prev) chk("m_rd_valid", 32'(m_if.rd_valid), 32'(m_req_prev));
      if (m_if.rd_valid) begin
        if (m_q.size() == 0) chk("m_rd_unexpected", 32'd1, 32'd0);
        else begin
          e = m_q.pop_front();
          chk($sformatf("m_rd_data[%0d]", e.sel), m_if.rd_data, e.val);
        end
      end
      if (s_if.rd_valid || s_req_prev) chk("s_rd_valid", 32'(s_if.rd_valid), 32'(s_req_prev));
      if (s_if.rd_valid) begin
        if (s_q.size() == 0) chk("s_rd_unexpected", 32'd1, 32'd0);
        else begin
          e = s_q.pop_front();
          chk($sformatf("s_rd_data[%0d]", e.sel), 32'(s_if.rd_data), e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Expected counter values for the main instance; indices 6 and 7 stay 0.
  logic [31:0] exp_c [8];

  task automatic zero_exp();
    for (int k = 0; k < 8; k++) exp_c[k] = '0;
  endtask

  task automatic clear_inputs();
    m_if.st_valid = '0; m_if.st_addr_valid = '0; m_if.st_addr = '0; m_if.st_funct3 = '0;
    m_if.ld_valid = '0; m_if.ld_addr_valid = '0; m_if.ld_addr = '0; m_if.ld_funct3 = '0;
    s_if.st_valid = '0; s_if.st_addr_valid = '0; s_if.st_addr = '0; s_if.st_funct3 = '0;
    s_if.ld_valid = '0; s_if.ld_addr_valid = '0; s_if.ld_addr = '0; s_if.ld_funct3 = '0;
  endtask

  task automatic set_st(input int i, input logic [2:0] f3, input logic [31:0] a,
                        input logic av);
    m_if.st_valid[i] = 1'b1; m_if.st_addr_valid[i] = av;
    m_if.st_addr[i] = a; m_if.st_funct3[i] = f3;
  endtask

  task automatic set_ld(input int i, input logic [2:0] f3, input logic [31:0] a,
                        input logic av);
    m_if.ld_valid[i] = 1'b1; m_if.ld_addr_valid[i] = av;
    m_if.ld_addr[i] = a; m_if.ld_funct3[i] = f3;
  endtask

  // One sampled cycle of the current inputs, with its expected classification.
  task automatic sample(input int nf, input int np, input bit both);
    m_if.en = 1'b1;
    @(posedge clk); #1;
    exp_c[0] += 1;
    if (both) exp_c[1] += 1;
    if (nf > 0) exp_c[2] += 1;
    exp_c[3] += 32'(nf);
    exp_c[4] += 32'(np);
    if (32'(nf) > exp_c[5]) exp_c[5] = 32'(nf);
  endtask

  task automatic drain();
    m_if.en = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic read_all();
    for (int s = 0; s < 8; s++) begin
      m_if.rd_req = 1'b1;
      m_if.rd_sel = 3'(s);
      m_q.push_back('{s, exp_c[s]});
      @(posedge clk); #1;
    end
    m_if.rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clr_main();
    m_if.clr = 1'b1;
    @(posedge clk); #1;
    m_if.clr = 1'b0;
    zero_exp();
  endtask

  typedef struct {
    logic [2:0]  sf3;
    logic [31:0] sa;
    logic        sav;
    logic [2:0]  lf3;
    logic [31:0] la;
    logic        lav;
    int          nf;
    int          np;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'b010, 32'h100, 1'b1, 3'b010, 32'h100, 1'b1, 1, 0};  // SW / LW
    vecs[1] = '{3'b000, 32'h101, 1'b1, 3'b001, 32'h100, 1'b1, 0, 1};  // SB / LH
    vecs[2] = '{3'b011, 32'h100, 1'b1, 3'b010, 32'h100, 1'b1, 0, 0};  // bad store funct3
    vecs[3] = '{3'b010, 32'h100, 1'b0, 3'b010, 32'h100, 1'b1, 0, 0};  // store addr unresolved
    vecs[4] = '{3'b010, 32'h100, 1'b1, 3'b010, 32'h100, 1'b0, 0, 0};  // load addr unresolved
    vecs[5] = '{3'b001, 32'h102, 1'b1, 3'b100, 32'h103, 1'b1, 1, 0};  // SH hi / LBU
    vecs[6] = '{3'b010, 32'h104, 1'b1, 3'b010, 32'h100, 1'b1, 0, 0};  // other word
    vecs[7] = '{3'b000, 32'h100, 1'b1, 3'b000, 32'h101, 1'b1, 0, 0};  // disjoint bytes
    vecs[8] = '{3'b001, 32'h100, 1'b1, 3'b010, 32'h100, 1'b1, 0, 1};  // SH / LW
    vecs[9] = '{3'b010, 32'h200, 1'b1, 3'b101, 32'h202, 1'b1, 1, 0};  // SW / LHU

    rst = 1'b1;
    m_if.en = 1'b0; m_if.clr = 1'b0; m_if.rd_req = 1'b0; m_if.rd_sel = '0;
    s_if.en = 1'b0; s_if.clr = 1'b0; s_if.rd_req = 1'b0; s_if.rd_sel = '0;
    clear_inputs();
    zero_exp();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", 32'(m_if.rd_valid), 32'd0);
    chk("rst_rd_data", m_if.rd_data, 32'd0);
    rst = 1'b0;

    // Idle cycles: only CYCLES moves.
    for (int c = 0; c < 10; c++) sample(0, 0, 0);
    drain();
    read_all();

    // SW/LW held four cycles.
    clr_main();
    set_st(0, 3'b010, 32'h100, 1'b1);
    set_ld(0, 3'b010, 32'h100, 1'b1);
    repeat (4) sample(1, 0, 1);
    drain();
    read_all();

    // Single-pair table.
    clr_main();
    for (int v = 0; v < 10; v++) begin
      clear_inputs();
      set_st(0, vecs[v].sf3, vecs[v].sa, vecs[v].sav);
      set_ld(0, vecs[v].lf3, vecs[v].la, vecs[v].lav);
      sample(vecs[v].nf, vecs[v].np, 1);
      drain();
      read_all();
    end

    // Partial, then a covering SW reclassifies the same load as full only.
    clr_main();
    set_st(0, 3'b000, 32'h101, 1'b1);
    set_ld(0, 3'b001, 32'h100, 1'b1);
    repeat (3) sample(0, 1, 1);
    set_st(1, 3'b010, 32'h100, 1'b1);
    repeat (2) sample(1, 0, 1);
    drain();
    read_all();

    // Four loads covered, then two.
    clr_main();
    set_st(0, 3'b010, 32'h100, 1'b1);
    for (int j = 0; j < 4; j++) set_ld(j, 3'b010, 32'h100, 1'b1);
    sample(4, 0, 1);
    m_if.ld_valid[2] = 1'b0;
    m_if.ld_valid[3] = 1'b0;
    sample(2, 0, 1);
    drain();
    read_all();

    // en low with matching traffic: nothing counted.
    set_st(0, 3'b010, 32'h100, 1'b1);
    set_ld(0, 3'b010, 32'h100, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    clear_inputs();
    read_all();

    // clr with a same-cycle read returns the old value; the next read returns 0.
    m_if.clr = 1'b1; m_if.rd_req = 1'b1; m_if.rd_sel = 3'(CntFullLoads);
    m_q.push_back('{3, exp_c[3]});
    @(posedge clk); #1;
    m_if.clr = 1'b0;
    zero_exp();
    m_q.push_back('{3, 32'd0});
    @(posedge clk); #1;
    m_if.rd_req = 1'b0;

    // A sample in flight when clr arrives is dropped, and the clear wins.
    set_st(0, 3'b010, 32'h100, 1'b1);
    set_ld(0, 3'b010, 32'h100, 1'b1);
    m_if.en = 1'b1;
    @(posedge clk); #1;
    m_if.clr = 1'b1;
    @(posedge clk); #1;
    m_if.clr = 1'b0;
    drain();
    read_all();

    // Reset mid-operation drops the in-flight sample and a pending read response.
    set_st(0, 3'b010, 32'h100, 1'b1);
    set_ld(0, 3'b010, 32'h100, 1'b1);
    sample(1, 0, 1);
    sample(1, 0, 1);
    rst = 1'b1; m_if.rd_req = 1'b1; m_if.rd_sel = 3'(CntCycles);
    @(posedge clk); #1;
    rst = 1'b0; m_if.rd_req = 1'b0;
    zero_exp();
    drain();
    read_all();

    // 4-bit counters saturate at 15.
    s_if.st_valid[0] = 1'b1; s_if.st_addr_valid[0] = 1'b1;
    s_if.st_addr[0] = 32'h100; s_if.st_funct3[0] = 3'b010;
    s_if.ld_valid[0] = 1'b1; s_if.ld_addr_valid[0] = 1'b1;
    s_if.ld_addr[0] = 32'h100; s_if.ld_funct3[0] = 3'b010;
    s_if.en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    s_if.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 8; s++) begin
      s_if.rd_req = 1'b1;
      s_if.rd_sel = 3'(s);
      s_q.push_back('{s, (s <= 3) ? 32'd15 : ((s == 5) ? 32'd1 : 32'd0)});
      @(posedge clk); #1;
    end
    s_if.clr = 1'b1; s_if.rd_sel = 3'(CntCycles);
    s_q.push_back('{0, 32'd15});
    @(posedge clk); #1;
    s_if.clr = 1'b0;
    s_q.push_back('{0, 32'd0});
    @(posedge clk); #1;
    s_if.rd_req = 1'b0;

    for (int w = 0; w < 10 && (m_q.size() != 0 || s_q.size() != 0); w++) begin
      @(posedge clk); #1;
    end
    chk("m_queue_empty", 32'(m_q.size()), 32'd0);
    chk("s_queue_empty", 32'(s_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsq_fwd_profiler.md
# lsq_fwd_profiler

Synthesizable, parametrised performance monitor for store-to-load forwarding opportunities between the store queue and the load reservation station. Every cycle it compares each occupied load entry against each valid store entry and classifies the load as fully covered, partially overlapped or unmatched. It accumulates saturating event counters, readable through a one-cycle request/response port. It sits beside the LSQ, is driven only by explicit ports, and has no effect on core behaviour.

## Interface
- ST_ENTRIES, 8: number of store-queue entries observed.
- LD_ENTRIES, 8: number of load-RS entries observed.
- CNT_W, 32: width of each event counter.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  when low, the cycle is not sampled.
- clr  in  1  synchronous clear of all counters and the pipeline.
- st_valid  in  ST_ENTRIES  store entry occupied.
- st_addr_valid  in  ST_ENTRIES  store address resolved.
- st_addr  in  ST_ENTRIES×32  store byte address.
- st_funct3  in  ST_ENTRIES×3  store funct3.
- ld_valid, ld_addr_valid, ld_addr, ld_funct3  in  same shapes over LD_ENTRIES  load-side equivalents.
- rd_req  in  1  counter read request.
- rd_sel  in  3  counter index.
- rd_valid  out  1  read response valid.
- rd_data  out  CNT_W  read response value.

## Operation
- Pair check (st i, ld j): both valid and both addr_valid, and st_addr[31:2]==ld_addr[31:2].
- Store byte mask:
  - 000 gives 0001<<a[1:0].
  - 001 gives 0011<<a[1:0].
  - 010 gives 1111.
  - Any other funct3 gives 0000, which never matches.
- Load byte mask:
  - 000 and 100 give 0001<<a[1:0].
  - 001 and 101 give 0011<<a[1:0].
  - All other funct3 give 1111.
- Full: (stmask & ldmask)==ldmask. Partial: nonzero overlap, not full.
- Per-load classification: FULL if any store gives full. Otherwise PARTIAL if any store gives partial. Otherwise none. Each load counts at most once per cycle.
- Per-cycle stage-0 results:
  - nfull = number of FULL loads, range 0..LD_ENTRIES.
  - npart = number of PARTIAL loads.
  - both = (any st_valid) && (any ld_valid).
- Counters, indexed by rd_sel:
  - 0 CYCLES: +1 per sampled cycle.
  - 1 BOTH_NONEMPTY: +1 when both.
  - 2 CYC_FULL: +1 when nfull>0.
  - 3 FULL_LOADS: +nfull.
  - 4 PART_LOADS: +npart.
  - 5 MAX_FULL: high-water mark of nfull, zero-extended.
  - 6 and 7 read 0.
- All accumulating counters saturate at 2^CNT_W−1 and never wrap. An addition that would exceed the maximum clamps to it.

## Timing
- Stage 0, combinational: match classification.
- Stage 1, registered: s1_vld, s1_nfull, s1_npart, s1_both. s1_vld = en && !clr.
- Stage 2: counters update from stage 1 when s1_vld. Inputs at cycle t are visible in counters at the edge ending cycle t+1, so a read issued in cycle t+2 returns them.
- Read: rd_req in cycle t gives rd_valid=1 and rd_data in cycle t+1. Both are registered.
  - rd_valid is high for exactly one cycle per request.
  - Back-to-back requests are accepted every cycle.
- clr handling:
  - The counter clear wins over a same-cycle update.
  - s1_vld is forced to 0, so the in-flight sample is dropped.
  - A read requested in the same cycle as clr returns the pre-clear value.
- en low: no sample enters stage 1. A sample already in stage 1 still commits. Reads work regardless of en.
- Reset values: all counters 0, s1_vld 0, rd_valid 0, rd_data 0.
- Reset mid-operation discards stage 1 and any pending read response.

## Structure
- Shared package (rv32i_types or a perf package) holds:
  - lsq_fwd_cnt_e: counter index enum, 3 bits.
  - Store and load byte-mask functions, shared with the forwarding logic.
  - Default entry-count constants.
- Sub-module lsq_fwd_pair: one store/load pair in, {full, partial} out. It is instantiated ST_ENTRIES×LD_ENTRIES times via generate.
- Popcount and the saturating adders stay in the top module.

## Test plan
- Reset, then idle 10 cycles, then read each index 0–7:
  - CYCLES=10.
  - All other counters 0.
  - rd_valid is high one cycle after each rd_req.
- SW store at 0x100 and LW load at 0x100, all valid, held 4 cycles, then drained:
  - CYC_FULL=4, FULL_LOADS=4, BOTH_NONEMPTY=4, MAX_FULL=1.
- SB at 0x101 against LH at 0x100: PART_LOADS +1 per cycle, FULL_LOADS unchanged. Adding an SW at 0x100 reclassifies the load as FULL only.
- Four loads fully covered in one cycle, then two: FULL_LOADS=6, CYC_FULL=2, MAX_FULL=4.
- Store with funct3=011 matching the address, or addr_valid=0 on either side: no match counted.
- CNT_W=4, held full match 20 cycles: CYCLES and CYC_FULL stick at 15. clr with a same-cycle rd_req returns 15, and a next-cycle read returns 0.
